id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the opcode decoder.
- Registers the decoded control bundle, operands and register indices into EX.
- Detects load-use hazards and inserts bubbles; holds EX for multi-cycle multiplies.
- Produces the single stall request used by the PC and IF/ID registers.

Parameters:
- CTRL_W, 20, width of packed control bundle (layout fixed in package)
- MUL_CYCLES, 4, EX occupancy of a mul instruction in cycles (>=1; 1 = no extra hold)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_ctrl_i  in  CTRL_W  packed decoder outputs: {alu_opcode[4:0], ByteControl[3:0], coprocessor, Arith_u, link, Jr, jump, RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg} (MSB..LSB)
- id_is_mul_i  in  1  decoded opcode is mul (6'd28)
- id_rs_i / id_rt_i / id_rd_i  in  5 each  register indices
- id_rs_data_i / id_rt_data_i  in  32 each  register file read data
- id_imm_i  in  32  extended immediate
- id_pc4_i  in  32  PC+4 of ID instruction
- flush_i  in  1  ID instruction is wrong-path (branch/jump taken)
- ex_hold_i  in  1  downstream (MEM) cannot accept; freeze EX
- stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
- ex_valid_o  out  1  EX holds a real instruction
- ex_ctrl_o  out  CTRL_W  registered control bundle
- ex_rs_o / ex_rt_o  out  5 each  registered indices (for forwarding)
- ex_dest_o  out  5  registered destination: link ? 31 : RegDst ? rd : rt
- ex_rs_data_o / ex_rt_data_o / ex_imm_o / ex_pc4_o  out  32 each  registered data
- ex_mul_busy_o  out  1  mul hold counter non-zero

Behaviour:
- Reset: all registered outputs 0; mul counter 0; stall_o 0.
- Bubble = ex_valid 0, ex_ctrl 0 (incl. ByteControl 4'b0000), ex_dest 0; data fields load don't-care (implement as load-through).
- load_use = ex_valid & ex_ctrl.MemtoReg & ex_ctrl.RegWrite & ex_dest!=0 & id_valid_i & (ex_dest==id_rs_i | ex_dest==id_rt_i). rt compare applies for every opcode (conservative).
- Per-cycle priority, highest first:
  1. rst: reset values.
  2. ex_hold_i: EX registers and counter unchanged; stall_o=1.
  3. mul counter != 0: EX unchanged; counter decrements; stall_o=1.
  4. load_use: EX loads bubble; stall_o=1; ID instruction retained upstream and re-presented next cycle.
  5. flush_i or !id_valid_i: EX loads bubble; stall_o=0.
  6. Otherwise: EX loads ID instruction; stall_o=0. If id_is_mul_i, counter loads MUL_CYCLES-1.
- A flush under cases 2 or 3 does not alter EX; upstream clears IF/ID itself.
- Latency: 1 cycle ID->EX when not stalled. A mul occupies EX for exactly MUL_CYCLES cycles; ex_mul_busy_o=1 for the first MUL_CYCLES-1 of them.
- stall_o is purely combinational from current EX state and ID inputs; no combinational path from ex_ctrl_o back into id_ctrl_i.
- Register $0 is never a hazard source.
- Counter width: $clog2(MUL_CYCLES)+1; no wrap (stops at 0).

Decomposition:
- Shared package (cpu_pkg):
  - CTRL_W and bit-index constants for each control field.
  - ByteControl codes Wd/Hw/By/none.
  - Register-index constant REG_RA=31.
  - alu_opcode family codes.
- Natural sub-module: hazard_detect (combinational load_use compare). Counter and registers stay in id_ex_stage.

Test Plan:
- Reset mid-operation: mul in EX with counter=2, rst=1 one cycle -> next cycle ex_valid_o=0, ex_ctrl_o=0, ex_mul_busy_o=0, stall_o=0.
- Load-use: lw $8 in EX, then add $9,$8,$10 in ID -> stall_o=1 one cycle, bubble in EX; next cycle add enters EX with ex_dest_o=9.
- No false hazard: lw $0 in EX, then add using $0 -> stall_o=0; add enters EX next cycle.
- jal: in ID -> ex_dest_o=31, link bit set; ex_pc4_o equals id_pc4_i. flush_i=1 on the following instruction -> bubble.
- Mul hold, MUL_CYCLES=4: mul enters EX -> stall_o=1 for 3 cycles, ex_mul_busy_o 1,1,1,0; instruction behind enters EX on cycle 5. Repeat with MUL_CYCLES=1 -> no stall.
- Simultaneous events: ex_hold_i=1 together with load_use and flush_i -> EX unchanged, stall_o=1. Release hold -> load_use bubble is applied the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg: control-bundle layout and shared codes for ID/EX        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int CTRL_W = 20;

  // Bit positions inside the packed control bundle (LSB first)
  localparam int CB_MEMTOREG = 0;
  localparam int CB_MEMWRITE = 1;
  localparam int CB_BRANCH   = 2;
  localparam int CB_ALUSRC   = 3;
  localparam int CB_REGDST   = 4;
  localparam int CB_REGWRITE = 5;
  localparam int CB_JUMP     = 6;
  localparam int CB_JR       = 7;
  localparam int CB_LINK     = 8;
  localparam int CB_ARITH_U  = 9;
  localparam int CB_COPROC   = 10;
  localparam int CB_BYTE_LO  = 11;
  localparam int CB_BYTE_HI  = 14;
  localparam int CB_ALUOP_LO = 15;
  localparam int CB_ALUOP_HI = 19;

  localparam logic [3:0] BYTE_WD   = 4'b1111;
  localparam logic [3:0] BYTE_HW   = 4'b0011;
  localparam logic [3:0] BYTE_BY   = 4'b0001;
  localparam logic [3:0] BYTE_NONE = 4'b0000;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_NOR = 5'd5,
    ALU_SLT = 5'd6,
    ALU_SLL = 5'd7,
    ALU_SRL = 5'd8,
    ALU_SRA = 5'd9,
    ALU_LUI = 5'd10,
    ALU_MUL = 5'd11
  } alu_op_e;

  function automatic logic [4:0] ctrl_dest(input logic link, input logic regdst,
                                           input logic [4:0] rt, input logic [4:0] rd);
    return link ? REG_RA : (regdst ? rd : rt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_detect: load-use compare between EX load and ID sources   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_memtoreg_i,
  input  logic       ex_regwrite_i,
  input  logic [4:0] ex_dest_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       load_use_o
);

  logic w_ex_is_load;
  logic w_src_match;

  // rt is compared for every opcode; a spurious stall is cheaper than decoding use
  always_comb begin
    w_ex_is_load = ex_valid_i & ex_memtoreg_i & ex_regwrite_i & (ex_dest_i != 5'd0);
    w_src_match  = (ex_dest_i == id_rs_i) | (ex_dest_i == id_rt_i);
    load_use_o   = w_ex_is_load & id_valid_i & w_src_match;
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with load-use and mul stall |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int CTRL_W     = 20,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_is_mul_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic [4:0]        id_rd_i,
  input  logic [31:0]       id_rs_data_i,
  input  logic [31:0]       id_rt_data_i,
  input  logic [31:0]       id_imm_i,
  input  logic [31:0]       id_pc4_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [4:0]        ex_rs_o,
  output logic [4:0]        ex_rt_o,
  output logic [4:0]        ex_dest_o,
  output logic [31:0]       ex_rs_data_o,
  output logic [31:0]       ex_rt_data_o,
  output logic [31:0]       ex_imm_o,
  output logic [31:0]       ex_pc4_o,
  output logic              ex_mul_busy_o
);

  localparam int               CNT_W    = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic              ex_valid_q,   ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
  logic [4:0]        ex_rs_q,      ex_rs_d;
  logic [4:0]        ex_rt_q,      ex_rt_d;
  logic [4:0]        ex_dest_q,    ex_dest_d;
  logic [31:0]       ex_rs_data_q, ex_rs_data_d;
  logic [31:0]       ex_rt_data_q, ex_rt_data_d;
  logic [31:0]       ex_imm_q,     ex_imm_d;
  logic [31:0]       ex_pc4_q,     ex_pc4_d;
  logic [CNT_W-1:0]  mul_cnt_q,    mul_cnt_d;

  logic w_load_use;
  logic w_mul_active;
  logic w_bubble;

  hazard_detect u_hazard_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_memtoreg_i (ex_ctrl_q[CB_MEMTOREG]),
    .ex_regwrite_i (ex_ctrl_q[CB_REGWRITE]),
    .ex_dest_i     (ex_dest_q),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .load_use_o    (w_load_use)
  );

  always_comb begin
    w_mul_active = (mul_cnt_q != '0);
    w_bubble     = w_load_use | flush_i | ~id_valid_i;
    stall_o      = ~rst & (ex_hold_i | w_mul_active | w_load_use);
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_dest_d    = ex_dest_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_pc4_d     = ex_pc4_q;
    mul_cnt_d    = mul_cnt_q;

    if (ex_hold_i) begin
      mul_cnt_d = mul_cnt_q;
    end else if (w_mul_active) begin
      mul_cnt_d = mul_cnt_q - CNT_W'(1);
    end else begin
      // Data fields load through even for bubbles; only valid/ctrl/dest are cleared
      ex_rs_d      = id_rs_i;
      ex_rt_d      = id_rt_i;
      ex_rs_data_d = id_rs_data_i;
      ex_rt_data_d = id_rt_data_i;
      ex_imm_d     = id_imm_i;
      ex_pc4_d     = id_pc4_i;
      if (w_bubble) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_dest_d  = 5'd0;
        mul_cnt_d  = '0;
      end else begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = id_ctrl_i;
        ex_dest_d  = ctrl_dest(id_ctrl_i[CB_LINK], id_ctrl_i[CB_REGDST], id_rt_i, id_rd_i);
        mul_cnt_d  = id_is_mul_i ? MUL_LOAD : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rs_q      <= 5'd0;
      ex_rt_q      <= 5'd0;
      ex_dest_q    <= 5'd0;
      ex_rs_data_q <= 32'd0;
      ex_rt_data_q <= 32'd0;
      ex_imm_q     <= 32'd0;
      ex_pc4_q     <= 32'd0;
      mul_cnt_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dest_q    <= ex_dest_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_pc4_q     <= ex_pc4_d;
      mul_cnt_q    <= mul_cnt_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_ctrl_o     = ex_ctrl_q;
  assign ex_rs_o       = ex_rs_q;
  assign ex_rt_o       = ex_rt_q;
  assign ex_dest_o     = ex_dest_q;
  assign ex_rs_data_o  = ex_rs_data_q;
  assign ex_rt_data_o  = ex_rt_data_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_pc4_o      = ex_pc4_q;
  assign ex_mul_busy_o = w_mul_active;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_id_ex_stage: scoreboard bench for id_ex_stage (MUL 4 and 1)   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam logic [19:0] C_LW  = {5'd0,  4'b1111, 11'b00000101001};
  localparam logic [19:0] C_ADD = {5'd0,  4'b0000, 11'b00000110000};
  localparam logic [19:0] C_JAL = {5'd0,  4'b0000, 11'b00101100000};
  localparam logic [19:0] C_MUL = {5'd11, 4'b0000, 11'b00000110000};

  typedef struct {
    logic        v;
    logic [19:0] ctrl;
    logic [4:0]  dest;
    logic        busy;
    logic [31:0] pc4;
    logic [31:0] rsd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_is_mul, flush, hold;
  logic [19:0] id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rsd, id_rtd, id_imm, id_pc4;

  logic        stall4, valid4, busy4;
  logic [19:0] ctrl4;
  logic [4:0]  rs4, rt4, dest4;
  logic [31:0] rsd4, rtd4, imm4, pc44;
  logic        stall1, valid1, busy1;
  logic [19:0] ctrl1;
  logic [4:0]  rs1, rt1, dest1;
  logic [31:0] rsd1, rtd1, imm1, pc41;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(20), .MUL_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl), .id_is_mul_i(id_is_mul),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_rs_data_i(id_rsd), .id_rt_data_i(id_rtd),
    .id_imm_i(id_imm), .id_pc4_i(id_pc4), .flush_i(flush), .ex_hold_i(hold), .stall_o(stall4),
    .ex_valid_o(valid4), .ex_ctrl_o(ctrl4), .ex_rs_o(rs4), .ex_rt_o(rt4), .ex_dest_o(dest4),
    .ex_rs_data_o(rsd4), .ex_rt_data_o(rtd4), .ex_imm_o(imm4), .ex_pc4_o(pc44), .ex_mul_busy_o(busy4)
  );

  id_ex_stage #(.CTRL_W(20), .MUL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl), .id_is_mul_i(id_is_mul),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_rs_data_i(id_rsd), .id_rt_data_i(id_rtd),
    .id_imm_i(id_imm), .id_pc4_i(id_pc4), .flush_i(flush), .ex_hold_i(hold), .stall_o(stall1),
    .ex_valid_o(valid1), .ex_ctrl_o(ctrl1), .ex_rs_o(rs1), .ex_rt_o(rt1), .ex_dest_o(dest1),
    .ex_rs_data_o(rsd1), .ex_rt_data_o(rtd1), .ex_imm_o(imm1), .ex_pc4_o(pc41), .ex_mul_busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rsd_of(input logic [4:0] r);
    return 32'hA000_0000 | {27'd0, r};
  endfunction

  function automatic exp_t mk(input logic v, input logic [19:0] c, input logic [4:0] d,
                              input logic b, input logic [31:0] p, input logic [31:0] r);
    exp_t e;
    e.v = v; e.ctrl = c; e.dest = d; e.busy = b; e.pc4 = p; e.rsd = r;
    return e;
  endfunction

  function automatic exp_t bub();
    return mk(1'b0, 20'd0, 5'd0, 1'b0, 32'd0, 32'd0);
  endfunction

  task automatic drive(input logic v, input logic [19:0] c, input logic m,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc4);
    id_valid = v; id_ctrl = c; id_is_mul = m;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rsd = rsd_of(rs); id_rtd = 32'hB000_0000 | {27'd0, rt};
    id_imm = pc4 ^ 32'h0000_FFFF; id_pc4 = pc4;
  endtask

  task automatic idle();
    drive(1'b0, 20'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  // Called at a negedge with inputs already driven; checks stall, then EX after the edge
  task automatic step(input string tag, input logic skip_stall, input logic exp_stall, input exp_t e);
    exp_t x;
    #1;
    if (!skip_stall) chk({tag, "/stall"}, {31'd0, stall4}, {31'd0, exp_stall});
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, "/valid"}, {31'd0, valid4}, {31'd0, x.v});
    chk({tag, "/ctrl"},  {12'd0, ctrl4},  {12'd0, x.ctrl});
    chk({tag, "/dest"},  {27'd0, dest4},  {27'd0, x.dest});
    chk({tag, "/busy"},  {31'd0, busy4},  {31'd0, x.busy});
    if (x.v) begin
      chk({tag, "/pc4"}, pc44, x.pc4);
      chk({tag, "/rsd"}, rsd4, x.rsd);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step("reset", 1'b0, 1'b0, bub());

    // load-use on rs
    drive(1, C_LW, 0, 5'd1, 5'd8, 5'd0, 32'h100);
    step("lw8", 0, 0, mk(1, C_LW, 5'd8, 0, 32'h100, rsd_of(5'd1)));
    drive(1, C_ADD, 0, 5'd8, 5'd10, 5'd9, 32'h104);
    step("lu_bubble", 0, 1, bub());
    step("lu_add", 0, 0, mk(1, C_ADD, 5'd9, 0, 32'h104, rsd_of(5'd8)));

    // $0 destination is never a hazard
    drive(1, C_LW, 0, 5'd1, 5'd0, 5'd0, 32'h108);
    step("lw0", 0, 0, mk(1, C_LW, 5'd0, 0, 32'h108, rsd_of(5'd1)));
    drive(1, C_ADD, 0, 5'd0, 5'd0, 5'd5, 32'h10C);
    step("add0", 0, 0, mk(1, C_ADD, 5'd5, 0, 32'h10C, rsd_of(5'd0)));

    // jal then flushed wrong-path instruction
    drive(1, C_JAL, 0, 5'd0, 5'd0, 5'd0, 32'h400);
    step("jal", 0, 0, mk(1, C_JAL, 5'd31, 0, 32'h400, rsd_of(5'd0)));
    chk("jal/link", {31'd0, ctrl4[CB_LINK]}, 32'd1);
    drive(1, C_ADD, 0, 5'd2, 5'd3, 5'd4, 32'h404);
    flush = 1'b1;
    step("flush", 0, 0, bub());
    flush = 1'b0;

    // mul holds EX for 4 cycles
    drive(1, C_MUL, 1, 5'd3, 5'd4, 5'd12, 32'h500);
    step("mul", 0, 0, mk(1, C_MUL, 5'd12, 1, 32'h500, rsd_of(5'd3)));
    drive(1, C_ADD, 0, 5'd12, 5'd5, 5'd13, 32'h504);
    step("mul_h1", 0, 1, mk(1, C_MUL, 5'd12, 1, 32'h500, rsd_of(5'd3)));
    step("mul_h2", 0, 1, mk(1, C_MUL, 5'd12, 1, 32'h500, rsd_of(5'd3)));
    step("mul_h3", 0, 1, mk(1, C_MUL, 5'd12, 0, 32'h500, rsd_of(5'd3)));
    step("mul_next", 0, 0, mk(1, C_ADD, 5'd13, 0, 32'h504, rsd_of(5'd12)));

    // hold + load_use + flush together, then release
    drive(1, C_LW, 0, 5'd1, 5'd7, 5'd0, 32'h600);
    step("lw7", 0, 0, mk(1, C_LW, 5'd7, 0, 32'h600, rsd_of(5'd1)));
    drive(1, C_ADD, 0, 5'd7, 5'd2, 5'd14, 32'h604);
    flush = 1'b1; hold = 1'b1;
    step("hold", 0, 1, mk(1, C_LW, 5'd7, 0, 32'h600, rsd_of(5'd1)));
    hold = 1'b0;
    step("hold_rel", 0, 1, bub());
    flush = 1'b0;
    step("hold_add", 0, 0, mk(1, C_ADD, 5'd14, 0, 32'h604, rsd_of(5'd7)));

    // reset while a mul is mid-hold
    drive(1, C_MUL, 1, 5'd3, 5'd4, 5'd15, 32'h700);
    step("mul2", 0, 0, mk(1, C_MUL, 5'd15, 1, 32'h700, rsd_of(5'd3)));
    drive(1, C_ADD, 0, 5'd1, 5'd2, 5'd16, 32'h704);
    step("mul2_h", 0, 1, mk(1, C_MUL, 5'd15, 1, 32'h700, rsd_of(5'd3)));
    rst = 1'b1;
    step("rst_mid", 1, 0, bub());
    rst = 1'b0;
    idle();
    step("post_rst", 0, 0, bub());

    // MUL_CYCLES=1 instance never stalls on mul
    drive(1, C_MUL, 1, 5'd3, 5'd4, 5'd17, 32'h800);
    step("m1_mul", 0, 0, mk(1, C_MUL, 5'd17, 1, 32'h800, rsd_of(5'd3)));
    chk("m1/valid", {31'd0, valid1}, 32'd1);
    chk("m1/busy",  {31'd0, busy1},  32'd0);
    chk("m1/dest",  {27'd0, dest1},  32'd17);
    drive(1, C_ADD, 0, 5'd1, 5'd2, 5'd18, 32'h804);
    #1;
    chk("m1/stall", {31'd0, stall1}, 32'd0);
    step("m1_d4hold", 0, 1, mk(1, C_MUL, 5'd17, 1, 32'h800, rsd_of(5'd3)));
    chk("m1/next_valid", {31'd0, valid1}, 32'd1);
    chk("m1/next_dest",  {27'd0, dest1},  32'd18);
    chk("m1/next_ctrl",  {12'd0, ctrl1},  {12'd0, C_ADD});

    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
